// File: rtl/ifetch_queue.sv
// ifetch_queue: in-order instruction fetch queue between the PC register,
// instruction memory and decode.
//
// Each fetch allocates an entry when its request is accepted, is filled when
// memory returns the word (responses come back in request order), and is
// handed to decode in order. A flush (taken branch) discards every queued
// entry. Responses still owed by memory for discarded fetches are counted in
// r_drop_cnt and thrown away as they arrive.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   pc, pc_valid, pc_ready   fetch address in; pc_ready gates PC advance
//   flush                    redirect; discards queued and in-flight fetches
//   imem_req_*               read request to instruction memory
//   imem_resp_*              in-order read data from instruction memory
//   instr_valid/instr/instr_pc/instr_ready   oldest fetched word to decode
module ifetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    output logic        pc_ready,
    input  logic        flush,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [PW-1:0]    r_alloc;
    logic [PW-1:0]    r_fill;
    logic [PW-1:0]    r_read;
    logic [PW-1:0]    r_drop_cnt;
    logic [DEPTH-1:0] r_filled;
    logic [31:0]      r_pc   [DEPTH];
    logic [31:0]      r_data [DEPTH];
    // Low during reset and for the first cycle after it, so no request is
    // issued until the memory side has also come out of reset.
    logic             r_live;

    logic [AW-1:0] w_alloc_idx;
    logic [AW-1:0] w_fill_idx;
    logic [AW-1:0] w_read_idx;
    logic [PW-1:0] w_count;
    logic [PW-1:0] w_in_flight;
    logic [PW:0]   w_occupancy;
    logic          w_space;
    logic          w_act;
    logic          w_fire;
    logic          w_resp_take;
    logic          w_resp_drop;
    logic          w_consume;
    logic [PW:0]   w_flush_sum;
    logic [PW-1:0] w_flush_drop;

    assign w_alloc_idx = r_alloc[AW-1:0];
    assign w_fill_idx  = r_fill[AW-1:0];
    assign w_read_idx  = r_read[AW-1:0];
    assign w_count     = r_alloc - r_read;
    assign w_in_flight = r_alloc - r_fill;

    // Slots still owed to discarded fetches count against capacity so that a
    // post-flush burst can never overrun the queue.
    assign w_occupancy = {1'b0, w_count} + {1'b0, r_drop_cnt};
    assign w_space     = w_occupancy < (PW+1)'(DEPTH);
    assign w_act       = rst & r_live;

    assign imem_req_valid = pc_valid & w_space & ~flush & w_act;
    assign imem_req_addr  = pc;
    assign pc_ready       = imem_req_ready & w_space & ~flush & w_act;
    assign w_fire         = pc_valid & pc_ready;

    assign w_resp_take = imem_resp_valid & (r_drop_cnt == '0) & ~flush;
    assign w_resp_drop = imem_resp_valid & (r_drop_cnt != '0) & ~flush;

    assign instr_valid = w_act & (w_count != '0) & r_filled[w_read_idx];
    assign instr       = instr_valid ? r_data[w_read_idx] : '0;
    assign instr_pc    = instr_valid ? r_pc[w_read_idx]   : '0;
    assign w_consume   = instr_valid & instr_ready & ~flush;

    // Everything still owed by memory becomes a drop; a response landing in
    // the flush cycle itself settles one of them immediately.
    assign w_flush_sum = {1'b0, r_drop_cnt} + {1'b0, w_in_flight};
    always_comb begin
        w_flush_drop = w_flush_sum[PW-1:0];
        if (imem_resp_valid) begin
            if (w_flush_sum == '0) begin
                w_flush_drop = '0;
            end else begin
                w_flush_drop = w_flush_sum[PW-1:0] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_alloc    <= '0;
            r_fill     <= '0;
            r_read     <= '0;
            r_drop_cnt <= '0;
            r_filled   <= '0;
            r_live     <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (flush) begin
                // Stale filled bits are harmless: an entry is always
                // re-initialised on allocation before it can be read.
                r_alloc    <= '0;
                r_fill     <= '0;
                r_read     <= '0;
                r_drop_cnt <= w_flush_drop;
            end else begin
                if (w_fire) begin
                    r_alloc              <= r_alloc + 1'b1;
                    r_filled[w_alloc_idx] <= 1'b0;
                end
                if (w_resp_take) begin
                    r_fill               <= r_fill + 1'b1;
                    r_filled[w_fill_idx] <= 1'b1;
                end
                if (w_resp_drop) begin
                    r_drop_cnt <= r_drop_cnt - 1'b1;
                end
                if (w_consume) begin
                    r_read <= r_read + 1'b1;
                end
            end
        end
    end

    // Payload storage needs no reset; it is only observed through filled.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_pc[w_alloc_idx] <= pc;
        end
        if (rst && w_resp_take) begin
            r_data[w_fill_idx] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: in-order memory model with configurable latency,
// scoreboard of expected {pc, data} pushed on request fire and popped on
// decode consume.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    ifetch_queue #(.DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .pc_valid        (pc_valid),
        .pc_ready        (pc_ready),
        .flush           (flush),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    mreq_t       memq[$];
    exp_t        expq[$];
    logic [31:0] cons_pc[$];
    int          cons_cyc[$];
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          n_fire = 0;
    int          outstanding = 0;
    bit          rand_ready = 1'b0;
    int          pass_cnt = 0;
    int          chk_cnt = 0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_C3C3;
    endfunction

    // Drive memory response / random ready for this cycle and let outputs settle.
    task automatic pre();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (rand_ready) instr_ready = 1'($urandom_range(1, 0));
        if (!rst) begin
            memq.delete();
            outstanding = 0;
        end else if (memq.size() != 0 && memq[0].due <= cyc) begin
            assert (outstanding > 0)
                else $error("FAIL illegal_resp: response with %0d outstanding, need >0", outstanding);
            imem_resp_valid = 1'b1;
            imem_resp_data  = mdata(memq[0].addr);
            void'(memq.pop_front());
            outstanding--;
        end
        #1;
    endtask

    // Record fires/consumes, score consumes, advance one clock.
    task automatic post();
        logic        fire;
        logic        cons;
        logic [31:0] npc;
        exp_t        e;
        fire = pc_valid & pc_ready;
        cons = instr_valid & instr_ready;
        npc  = pc;
        if (fire) begin
            chk_cnt++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== pc)
                $display("FAIL req_issue: valid=%b addr=%h, need valid=1 addr=%h",
                         imem_req_valid, imem_req_addr, pc);
            else pass_cnt++;
            memq.push_back('{pc, cyc + int'($urandom_range(lat_max, lat_min))});
            expq.push_back('{pc, mdata(pc)});
            outstanding++;
            n_fire++;
            npc = pc + 32'd4;
        end
        if (cons && !flush && rst) begin
            chk_cnt++;
            if (expq.size() == 0) begin
                $display("FAIL unexpected_instr: got pc=%h data=%h, need no instruction",
                         instr_pc, instr);
            end else begin
                e = expq.pop_front();
                if (instr_pc !== e.pc || instr !== e.data)
                    $display("FAIL instr_data: got pc=%h data=%h, need pc=%h data=%h",
                             instr_pc, instr, e.pc, e.data);
                else pass_cnt++;
            end
            cons_pc.push_back(instr_pc);
            cons_cyc.push_back(cyc);
        end
        if (flush || !rst) expq.delete();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        pc = npc;
    endtask

    task automatic tick();
        pre();
        post();
    endtask

    task automatic drain(input int budget, output bit ok);
        int n;
        n = 0;
        while ((expq.size() != 0 || memq.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        ok = (expq.size() == 0 && memq.size() == 0);
    endtask

    task automatic test_reset();
        rst = 1'b0; pc = 32'h0; pc_valid = 1'b1; flush = 1'b0;
        imem_req_ready = 1'b1; instr_ready = 1'b0;
        tick();
        pre();
        chk_cnt++;
        if (pc_ready !== 1'b0 || imem_req_valid !== 1'b0 || instr_valid !== 1'b0 ||
            instr !== 32'h0 || instr_pc !== 32'h0)
            $display("FAIL reset_outputs: pc_ready=%b req_valid=%b instr_valid=%b instr=%h instr_pc=%h, need all 0",
                     pc_ready, imem_req_valid, instr_valid, instr, instr_pc);
        else pass_cnt++;
        post();
        rst = 1'b1;
        pre();
        chk_cnt++;
        if (pc_ready !== 1'b0 || imem_req_valid !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL reset_after: pc_ready=%b req_valid=%b instr_valid=%b, need 0 0 0",
                     pc_ready, imem_req_valid, instr_valid);
        else pass_cnt++;
        post();
        pc_valid = 1'b0;
        pre();
        chk_cnt++;
        if (pc_ready !== 1'b1 || imem_req_valid !== 1'b0)
            $display("FAIL reset_release: pc_ready=%b req_valid=%b, need 1 0",
                     pc_ready, imem_req_valid);
        else pass_cnt++;
        post();
    endtask

    task automatic test_stream();
        int n;
        bit ok;
        lat_min = 1; lat_max = 1;
        cons_pc.delete(); cons_cyc.delete();
        n_fire = 0; n = 0;
        pc = 32'h0; pc_valid = 1'b1; instr_ready = 1'b1;
        while (n_fire < 4 && n < 20) begin tick(); n++; end
        pc_valid = 1'b0;
        drain(50, ok);
        chk_cnt++;
        if (!ok || cons_pc.size() != 4)
            $display("FAIL stream_count: drained=%b consumed=%0d, need 1 and 4", ok, cons_pc.size());
        else pass_cnt++;
        for (int i = 0; i < cons_pc.size(); i++) begin
            chk_cnt++;
            if (cons_pc[i] !== 32'(4 * i))
                $display("FAIL stream_order: idx %0d pc=%h, need %h", i, cons_pc[i], 32'(4 * i));
            else pass_cnt++;
        end
        for (int i = 1; i < cons_cyc.size(); i++) begin
            chk_cnt++;
            if (cons_cyc[i] != cons_cyc[i-1] + 1)
                $display("FAIL stream_gap: consume %0d at cycle %0d, need %0d",
                         i, cons_cyc[i], cons_cyc[i-1] + 1);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int base;
        bit ok;
        lat_min = 1; lat_max = 1;
        n_fire = 0;
        pc = 32'h200; pc_valid = 1'b1; instr_ready = 1'b0;
        repeat (8) tick();
        pre();
        chk_cnt++;
        if (n_fire != 4 || pc_ready !== 1'b0)
            $display("FAIL bp_full: fires=%0d pc_ready=%b, need 4 and 0", n_fire, pc_ready);
        else pass_cnt++;
        post();
        base = n_fire;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        repeat (6) tick();
        chk_cnt++;
        if (n_fire != base + 1)
            $display("FAIL bp_one_more: fires=%0d, need %0d", n_fire, base + 1);
        else pass_cnt++;
        pc_valid = 1'b0; instr_ready = 1'b1;
        drain(50, ok);
        chk_cnt++;
        if (!ok) $display("FAIL bp_drain: expq=%0d memq=%0d, need 0 0", expq.size(), memq.size());
        else pass_cnt++;
    endtask

    task automatic test_flush_inflight();
        bit ok;
        lat_min = 3; lat_max = 3;
        cons_pc.delete();
        pc = 32'h10; pc_valid = 1'b1; instr_ready = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        pre();
        chk_cnt++;
        if (pc_ready !== 1'b0 || imem_req_valid !== 1'b0)
            $display("FAIL flush_noreq: pc_ready=%b req_valid=%b, need 0 0", pc_ready, imem_req_valid);
        else pass_cnt++;
        post();
        flush = 1'b0;
        pc = 32'h40;
        tick();
        pc_valid = 1'b0;
        drain(50, ok);
        chk_cnt++;
        if (!ok || cons_pc.size() != 1 || cons_pc[0] !== 32'h40)
            $display("FAIL flush_first: drained=%b consumed=%0d first=%h, need 1 1 00000040",
                     ok, cons_pc.size(), (cons_pc.size() != 0) ? cons_pc[0] : 32'hx);
        else pass_cnt++;
        chk_cnt++;
        if (dut.r_drop_cnt !== '0)
            $display("FAIL flush_dropcnt: drop_cnt=%0d, need 0", dut.r_drop_cnt);
        else pass_cnt++;
    endtask

    task automatic test_flush_simul();
        bit ok;
        lat_min = 1; lat_max = 1;
        cons_pc.delete();
        pc = 32'h80; pc_valid = 1'b1; instr_ready = 1'b1;
        tick();
        pc_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        pre();
        chk_cnt++;
        if (dut.r_drop_cnt !== '0)
            $display("FAIL simul_dropcnt: drop_cnt=%0d, need 0", dut.r_drop_cnt);
        else pass_cnt++;
        post();
        for (int i = 0; i < 3; i++) begin
            pre();
            chk_cnt++;
            if (instr_valid !== 1'b0)
                $display("FAIL simul_stale: cycle %0d instr_valid=%b, need 0", i, instr_valid);
            else pass_cnt++;
            post();
        end
        pc = 32'h90; pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        drain(30, ok);
        chk_cnt++;
        if (!ok || cons_pc.size() != 1 || cons_pc[0] !== 32'h90)
            $display("FAIL simul_next: drained=%b consumed=%0d, need 1 and 1 at 00000090",
                     ok, cons_pc.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        lat_min = 1; lat_max = 1;
        cons_pc.delete();
        pc = 32'h300; pc_valid = 1'b1; instr_ready = 1'b0;
        repeat (3) tick();
        pc_valid = 1'b0;
        repeat (2) tick();
        pre();
        chk_cnt++;
        if (instr_valid !== 1'b1)
            $display("FAIL rmid_before: instr_valid=%b, need 1", instr_valid);
        else pass_cnt++;
        post();
        rst = 1'b0; pc_valid = 1'b1;
        pre();
        chk_cnt++;
        if (instr_valid !== 1'b0 || pc_ready !== 1'b0)
            $display("FAIL rmid_during: instr_valid=%b pc_ready=%b, need 0 0", instr_valid, pc_ready);
        else pass_cnt++;
        post();
        rst = 1'b1; pc = 32'h100;
        pre();
        chk_cnt++;
        if (pc_ready !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL rmid_after: pc_ready=%b instr_valid=%b, need 0 0", pc_ready, instr_valid);
        else pass_cnt++;
        post();
        tick();
        pc_valid = 1'b0; instr_ready = 1'b1;
        drain(30, ok);
        chk_cnt++;
        if (!ok || cons_pc.size() != 1 || cons_pc[0] !== 32'h100)
            $display("FAIL rmid_first: drained=%b consumed=%0d, need 1 and 1 at 00000100",
                     ok, cons_pc.size());
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int n;
        bit ok;
        lat_min = 1; lat_max = 4;
        cons_pc.delete();
        n_fire = 0; n = 0;
        rand_ready = 1'b1;
        pc = 32'h1000; pc_valid = 1'b1;
        while (n_fire < 20 && n < 300) begin tick(); n++; end
        pc_valid = 1'b0;
        drain(500, ok);
        rand_ready = 1'b0; instr_ready = 1'b1;
        chk_cnt++;
        if (!ok || cons_pc.size() != 20)
            $display("FAIL wrap_count: drained=%b consumed=%0d, need 1 and 20", ok, cons_pc.size());
        else pass_cnt++;
        chk_cnt++;
        if (cons_pc.size() == 0 || cons_pc[0] !== 32'h1000)
            $display("FAIL wrap_first: consumed=%0d, need first pc 00001000", cons_pc.size());
        else pass_cnt++;
        for (int i = 1; i < cons_pc.size(); i++) begin
            chk_cnt++;
            if (cons_pc[i] !== cons_pc[i-1] + 32'd4)
                $display("FAIL wrap_seq: idx %0d pc=%h, need %h", i, cons_pc[i], cons_pc[i-1] + 32'd4);
            else pass_cnt++;
        end
        repeat (3) tick();
        pre();
        chk_cnt++;
        if (instr_valid !== 1'b0)
            $display("FAIL wrap_empty: instr_valid=%b, need 0", instr_valid);
        else pass_cnt++;
        post();
    endtask

    initial begin
        rst = 1'b0; pc = '0; pc_valid = 1'b0; flush = 1'b0;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
        instr_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_inflight();
        test_flush_simul();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set queue entries; legal values are powers of two, 2..16.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous and active-low.
REQ-004 pc  input  32  SHALL carry the fetch address from the PC register.
REQ-005 pc_valid  input  1  SHALL qualify pc.
REQ-006 pc_ready  output  1  SHALL indicate a fetch for pc is accepted this cycle; PC advance is gated by it.
REQ-007 flush  input  1  SHALL be the taken-branch redirect (PCsrc), discarding all queued and in-flight fetches.
REQ-008 imem_req_valid  output  1  SHALL request an instruction-memory read.
REQ-009 imem_req_addr  output  32  SHALL be the read address.
REQ-010 imem_req_ready  input  1  SHALL be the memory acceptance signal.
REQ-011 imem_resp_valid  input  1  SHALL mark returned data; responses are in request order, any latency >= 1 cycle.
REQ-012 imem_resp_data  input  32  SHALL be the returned instruction word.
REQ-013 instr_valid  output  1  SHALL indicate instr/instr_pc are valid for decode.
REQ-014 instr  output  32  SHALL be the oldest fetched instruction.
REQ-015 instr_pc  output  32  SHALL be the address instr was fetched from.
REQ-016 instr_ready  input  1  SHALL be the decode acceptance signal.

Function
REQ-017 Queue SHALL hold DEPTH entries {pc, data, filled} with alloc, fill and read pointers, each log2(DEPTH)+1 bits wide, wrapping modulo 2*DEPTH.
REQ-018 count = alloc - read; space SHALL be (count + drop_cnt) < DEPTH.
REQ-019 imem_req_valid SHALL equal pc_valid & space & ~flush & rst; imem_req_addr SHALL equal pc.
REQ-020 pc_ready SHALL equal imem_req_ready & space & ~flush & rst.
REQ-021 A request fire (pc_valid & pc_ready) SHALL allocate entry[alloc] with pc and filled=0, then alloc+1.
REQ-022 A response with drop_cnt=0 SHALL write data into entry[fill], set filled=1, then fill+1; the response becomes visible on instr the next cycle at the earliest.
REQ-023 A response with drop_cnt>0 SHALL be discarded, and drop_cnt SHALL decrement by 1.
REQ-024 instr_valid SHALL be 1 iff count>0 and entry[read].filled; instr/instr_pc SHALL then come from entry[read], else 0.
REQ-025 A consume (instr_valid & instr_ready) SHALL advance read by 1.
REQ-026 Full queue (count=DEPTH) SHALL deassert pc_ready; a consume and a request in the same cycle are both honoured only if space held at the start of the cycle.
REQ-027 On flush, alloc, fill and read SHALL all reset to 0, and the consume in that cycle SHALL be ignored.
REQ-028 On flush, drop_cnt_next SHALL be drop_cnt + (alloc - fill) - (imem_resp_valid ? 1 : 0), saturating at 0; a simultaneous response is therefore dropped.
REQ-029 No request SHALL issue in a flush cycle; fetching resumes the next cycle from the redirected pc.
REQ-030 drop_cnt SHALL be log2(DEPTH)+1 bits and SHALL never exceed DEPTH.
REQ-031 A response arriving with no outstanding or dropped fetch is illegal; behaviour is unspecified and a bench assertion SHALL flag it.

Reset
REQ-032 While rst=0 at a clock edge, pointers and drop_cnt SHALL clear to 0 and all filled bits SHALL clear.
REQ-033 During reset and the cycle after, instr_valid, imem_req_valid and pc_ready SHALL be 0 (pc_ready/imem_req_valid also forced low while rst=0); instr and instr_pc SHALL be 0.
REQ-034 Reset mid-operation SHALL abandon in-flight fetches; the system SHALL also reset memory, so no stale responses are expected.

Verification
REQ-035 Stream: pc=0,4,8,12, 1-cycle memory, instr_ready=1 -> instr_pc=0,4,8,12 in order with matching data, no gaps after the first.
REQ-036 Backpressure: instr_ready=0, DEPTH=4 -> exactly 4 requests fire, pc_ready=0 after; one consume -> one further request.
REQ-037 Flush with 2 in flight: fetch 0x10,0x14 (3-cycle latency), flush; then fetch 0x40 -> responses for 0x10,0x14 dropped, first instr_pc=0x40.
REQ-038 Flush with simultaneous response: 1 outstanding, resp_valid=1 in the flush cycle -> response dropped, drop_cnt=0 next cycle, no stale instr_valid.
REQ-039 Reset mid-stream: rst=0 for 1 cycle with count=3 -> instr_valid=0 and pc_ready=0 that cycle; after reset, pc=0x100 is the first instr_pc.
REQ-040 Wrap: 20 sequential fetches with random instr_ready and memory latency 1-4 -> every instr_pc = previous + 4, with no loss or duplication across pointer wrap.
